// File: rtl/serial_add_unit_if.sv
// Operand/result bundle between operand select, the serial adder and the ALU flag register.
interface serial_add_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cOut;
   logic             overflow;
   logic             zero;

   modport master (output start, sub, opA, opB,
                   input  busy, done, result, cOut, overflow, zero);
   modport slave  (input  start, sub, opA, opB,
                   output busy, done, result, cOut, overflow, zero);
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract: one full-adder bit per cycle, LSB first, WIDTH cycles per op.
module serial_add_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   serial_add_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

   logic             s, c_next;
   logic [WIDTH-1:0] res_shift;

   assign s         = a_q[0] ^ b_q[0] ^ carry_q;
   assign c_next    = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
   assign res_shift = {s, res_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               // subtraction is A + ~B with the +1 folded into the initial carry
               a_d     = bus.opA;
               b_d     = bus.sub ? ~bus.opB : bus.opB;
               carry_d = bus.sub;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = res_shift;
            carry_d = c_next;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               cout_d  = c_next;
               ovf_d   = carry_q ^ c_next;
               zero_d  = (res_shift == '0);
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.busy     = (state_q == S_RUN) || (state_q == S_DONE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.result   = res_q;
   assign bus.cOut     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
endmodule

// File: tb/tb_serial_add_unit.sv
// Randomized bench for serial_add_unit against a plain-arithmetic reference.
module tb_serial_add_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   serial_add_unit_if #(.WIDTH(W)) bus ();
   serial_add_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [W-1:0] res;
      logic         c, v, z;
   } ref_t;

   function automatic ref_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      ref_t r;
      logic [W:0]   sum;
      logic [W-1:0] bb;
      bb    = s ? ~b : b;
      sum   = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
      r.res = sum[W-1:0];
      r.c   = sum[W];
      r.v   = (a[W-1] == bb[W-1]) && (r.res[W-1] != a[W-1]);
      r.z   = (r.res == '0);
      return r;
   endfunction

   // Issue one op from IDLE (called at a negedge), poke start mid-RUN, check latency and outputs.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
      ref_t r;
      int   n;
      logic [W-1:0] held;
      r = model(a, b, s);
      bus.start = 1'b1; bus.opA = a; bus.opB = b; bus.sub = s;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.opA = $urandom; bus.opB = $urandom; bus.sub = ~s;
      n = 0;
      do begin
         @(posedge clk); n++;
         #1;
         bus.start = (n == 5);
         @(negedge clk);
      end while (!bus.done && n < 100);
      chk({tag, ".lat"}, 64'(n), 64'(W));
      chk({tag, ".res"}, 64'(bus.result), 64'(r.res));
      chk({tag, ".flags"}, {61'd0, bus.cOut, bus.overflow, bus.zero}, {61'd0, r.c, r.v, r.z});
      chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
      held = bus.result;
      @(negedge clk);
      chk({tag, ".idle"}, {62'd0, bus.busy, bus.done}, 64'd0);
      chk({tag, ".hold"}, 64'(bus.result), 64'(held));
   endtask

   logic [W-1:0] qa[$], qb[$];
   logic         qs[$];

   initial begin
      ref_t r;
      int   last, ndone, n;
      bus.start = 1'b0; bus.sub = 1'b0; bus.opA = '0; bus.opB = '0;
      repeat (3) @(negedge clk);
      chk("rst.out", {bus.result, 29'd0, bus.busy, bus.done, bus.cOut | bus.overflow | bus.zero}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'd5, 32'd3, 1'b0, "add5p3");
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "wrap");
      run_op(32'h7FFF_FFFF, 32'd1, 1'b0, "povf");
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "novf");
      run_op(32'd5, 32'd5, 1'b1, "sub5m5");
      run_op(32'd3, 32'd5, 1'b1, "sub3m5");
      run_op(32'h8000_0000, 32'd1, 1'b1, "subovf");
      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] a, b;
         a = $urandom; b = $urandom;
         if (i % 4 == 0) b = a;
         run_op(a, b, 1'($urandom), "rnd");
      end

      // start held high: accepts every W+2 cycles, operands sampled at each accept edge
      bus.start = 1'b1;
      last = -1; ndone = 0;
      for (int cyc = 0; cyc < 3 * (W + 2) + 2; cyc++) begin
         bus.opA = $urandom; bus.opB = $urandom; bus.sub = 1'($urandom);
         qa.push_back(bus.opA); qb.push_back(bus.opB); qs.push_back(bus.sub);
         @(posedge clk);
         @(negedge clk);
         if (bus.done) begin
            r = model(qa[cyc - W], qb[cyc - W], qs[cyc - W]);
            chk("b2b.res", 64'(bus.result), 64'(r.res));
            chk("b2b.flags", {61'd0, bus.cOut, bus.overflow, bus.zero}, {61'd0, r.c, r.v, r.z});
            if (last >= 0) chk("b2b.gap", 64'(cyc - last), 64'(W + 2));
            else chk("b2b.first", 64'(cyc), 64'(W));
            last = cyc; ndone++;
         end
      end
      chk("b2b.count", 64'(ndone), 64'd3);
      bus.start = 1'b0;
      repeat (W + 4) @(negedge clk);

      // reset during RUN aborts the op
      bus.start = 1'b1; bus.opA = 32'hFFFF_FFFF; bus.opB = 32'hFFFF_FFFF; bus.sub = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("rst.async", {bus.result, 29'd0, bus.busy, bus.done, bus.cOut | bus.overflow | bus.zero}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (bus.done || bus.busy) n++;
      end
      chk("rst.nodone", 64'(n), 64'd0);
      run_op(32'd7, 32'd9, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
